// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - region codes, GPIO offsets and FSM states for the MIO bus controller
package mio_pkg;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_GPIO = 2'd1,
    REG_CNT  = 2'd2
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RAM_WAIT = 2'd1,
    S_DONE     = 2'd2
  } state_e;

  localparam logic [3:0]  NIB_GPIO     = 4'hE;
  localparam logic [3:0]  NIB_CNT      = 4'hF;
  // Word offsets inside the GPIO region (byte address bits 27:2)
  localparam logic [25:0] GPIO_OFF_SW  = 26'd0;
  localparam logic [25:0] GPIO_OFF_LED = 26'd1;

  function automatic region_e decode_region(input logic [3:0] nib);
    region_e r;
    r = REG_RAM;
    if (nib == NIB_GPIO) r = REG_GPIO;
    else if (nib == NIB_CNT) r = REG_CNT;
    return r;
  endfunction

endpackage

// File: rtl/mio_counter.sv
// rtl/mio_counter.sv - free-running 32-bit counter with synchronous load
module mio_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // A load takes priority over the increment in the same cycle
  assign cnt_d = ld ? d : cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// rtl/mio_bus_ctrl.sv - CPU MIO port to RAM / GPIO / counter bus controller
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_WAIT  = 1,
  parameter int RAM_AW    = 10,
  parameter int GPIO_SW_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic [RAM_AW-1:0]    ram_addr,
  output logic                 ram_we,
  output logic [31:0]          ram_din,
  input  logic [31:0]          ram_dout,
  input  logic [GPIO_SW_W-1:0] gpio_in,
  output logic [31:0]          gpio_out,
  output logic [31:0]          cnt_val
);

  localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT - 1);

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              acc_we_q, acc_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       gpio_out_q, gpio_out_d;
  logic              cnt_ld;

  region_e           region;
  logic [25:0]       word_off;
  logic [31:0]       gpio_rd;
  logic [1:0]        unused_byte_lane;

  assign region           = decode_region(cpu_addr[31:28]);
  assign word_off         = cpu_addr[27:2];
  assign unused_byte_lane = cpu_addr[1:0];

  always_comb begin
    gpio_rd = '0;
    if (word_off == GPIO_OFF_SW)       gpio_rd = 32'(gpio_in);
    else if (word_off == GPIO_OFF_LED) gpio_rd = gpio_out_q;
  end

  mio_counter u_counter (
    .clk (clk),
    .rst (rst),
    .ld  (cnt_ld),
    .d   (cpu_wdata),
    .q   (cnt_val)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    acc_we_d   = acc_we_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    rdata_d    = rdata_q;
    gpio_out_d = gpio_out_q;
    cnt_ld     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          acc_we_d = cpu_we;
          case (region)
            REG_RAM: begin
              // Write strobe lands in the first wait cycle, once per access
              state_d    = S_RAM_WAIT;
              wait_d     = WAIT_INIT;
              ram_addr_d = cpu_addr[RAM_AW+1:2];
              ram_din_d  = cpu_wdata;
              ram_we_d   = cpu_we;
            end
            REG_GPIO: begin
              state_d = S_DONE;
              if (cpu_we) begin
                rdata_d = '0;
                if (word_off == GPIO_OFF_LED) gpio_out_d = cpu_wdata;
              end else begin
                rdata_d = gpio_rd;
              end
            end
            default: begin
              state_d = S_DONE;
              if (cpu_we) begin
                rdata_d = '0;
                cnt_ld  = 1'b1;
              end else begin
                rdata_d = cnt_val;
              end
            end
          endcase
        end
      end
      S_RAM_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = S_DONE;
          if (!acc_we_q) rdata_d = ram_dout;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      acc_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      rdata_q    <= '0;
      gpio_out_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      acc_we_q   <= acc_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      rdata_q    <= rdata_d;
      gpio_out_q <= gpio_out_d;
    end
  end

  assign cpu_ready = (state_q == S_DONE);
  assign cpu_rdata = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_din   = ram_din_q;
  assign gpio_out  = gpio_out_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb/tb_mio_bus_ctrl.sv - self-checking bench for mio_bus_ctrl
module tb_mio_bus_ctrl;

  localparam int TB_WAIT = 1;
  localparam int AW      = 10;
  localparam int SW      = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;
  logic [SW-1:0] gpio_in = '0;
  logic [31:0]   gpio_out;
  logic [31:0]   cnt_val;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] ram_mem [0:1023];
  logic [31:0] exp_mem [0:1023];
  logic [31:0] gpio_m       = '0;
  logic [31:0] last_rd      = '0;
  logic [31:0] cnt_base_val = '0;
  int          cnt_base_cyc = 0;

  mio_bus_ctrl #(.RAM_WAIT(TB_WAIT), .RAM_AW(AW), .GPIO_SW_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .cnt_val   (cnt_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ram_dout = ram_mem[ram_addr];
  always @(posedge clk) if (ram_we === 1'b1) ram_mem[ram_addr] <= ram_din;

  // Counter value expected in the cycle whose posedge count is c
  function automatic logic [31:0] exp_cnt(input int c);
    return cnt_base_val + 32'(c - cnt_base_cyc);
  endfunction

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input int c, output logic [31:0] e_rd, output int e_lat,
                              output int e_nwe);
    logic [3:0]  top;
    logic [25:0] off;
    int          idx;
    top = addr[31:28];
    off = addr[27:2];
    idx = int'(addr[11:2]);
    e_nwe = 0;
    if (top == 4'hE) begin
      e_lat = 1;
      if (we) begin
        e_rd = '0;
        if (off == 26'd1) gpio_m = wd;
      end else if (off == 26'd0) e_rd = {16'h0, gpio_in};
      else if (off == 26'd1)     e_rd = gpio_m;
      else                       e_rd = '0;
    end else if (top == 4'hF) begin
      e_lat = 1;
      if (we) begin
        e_rd = '0;
        cnt_base_val = wd;
        cnt_base_cyc = c + 1;
      end else e_rd = exp_cnt(c);
    end else begin
      e_lat = TB_WAIT + 1;
      if (we) begin
        e_nwe = 1;
        exp_mem[idx] = wd;
        e_rd = last_rd;
      end else e_rd = exp_mem[idx];
    end
    last_rd = e_rd;
  endtask

  // Drives one access from the current negedge and reports what the DUT did
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, input bit early_drop,
                        output int lat, output logic [31:0] rd, output int nwe,
                        output logic [AW-1:0] we_addr, output logic [31:0] we_din,
                        output logic rdy_after, output int acc_cyc, output logic [31:0] cnt_rdy);
    lat = -1; rd = '0; nwe = 0; we_addr = '0; we_din = '0; cnt_rdy = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    acc_cyc = cyc;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (early_drop && i == 1) cpu_req = 1'b0;
      if (ram_we === 1'b1) begin
        nwe++;
        we_addr = ram_addr;
        we_din  = ram_din;
      end
      if (cpu_ready === 1'b1) begin
        lat = i; rd = cpu_rdata; cnt_rdy = cnt_val;
        break;
      end
    end
    if (!hold) cpu_req = 1'b0;
    @(negedge clk);
    if (ram_we === 1'b1) nwe++;
    rdy_after = cpu_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({cpu_ready, ram_we} !== 2'b00) begin n_fail++; $display("FAIL reset_ready_we: got %b, expected 00", {cpu_ready, ram_we}); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 0", cpu_rdata); end
    n_checks++; if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_out: got %h, expected 0", gpio_out); end
    n_checks++; if (cnt_val !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h, expected 0", cnt_val); end
    n_checks++; if ({ram_addr, ram_din} !== '0) begin n_fail++; $display("FAIL reset_ram_bus: got %h/%h, expected 0/0", ram_addr, ram_din); end
    rst = 1'b1;
    cnt_base_val = '0; cnt_base_cyc = cyc; gpio_m = '0; last_rd = '0;
    repeat (5) @(negedge clk);
    n_checks++; if (cnt_val !== exp_cnt(cyc)) begin n_fail++; $display("FAIL reset_cnt_run: got %h, expected %h", cnt_val, exp_cnt(cyc)); end
  endtask

  task automatic test_ram_write();
    int lat, nwe, c, e_lat, e_nwe; logic [31:0] rd, wdin, cr, e_rd; logic [AW-1:0] wa; logic ra;
    model_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, cyc, e_rd, e_lat, e_nwe);
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL ram_wr_latency: got %0d, expected 2", lat); end
    n_checks++; if (nwe != 1) begin n_fail++; $display("FAIL ram_wr_we_count: got %0d, expected 1", nwe); end
    n_checks++; if (wa !== 10'd4) begin n_fail++; $display("FAIL ram_wr_addr: got %h, expected 004", wa); end
    n_checks++; if (wdin !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_wr_din: got %h, expected deadbeef", wdin); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL ram_wr_ready_pulse: got %b after pulse, expected 0", ra); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL ram_wr_rdata_hold: got %h, expected 0", rd); end
  endtask

  task automatic test_ram_read();
    int lat, nwe, c, e_lat, e_nwe; logic [31:0] rd, wdin, cr, e_rd; logic [AW-1:0] wa; logic ra;
    model_access(1'b0, 32'h0000_0010, 32'h0, cyc, e_rd, e_lat, e_nwe);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rd_data: got %h, expected deadbeef", rd); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL ram_rd_latency: got %0d, expected 2", lat); end
    n_checks++; if (nwe != 0) begin n_fail++; $display("FAIL ram_rd_no_we: got %0d strobes, expected 0", nwe); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL ram_rd_ready_pulse: got %b after pulse, expected 0", ra); end
  endtask

  task automatic test_gpio();
    int lat, nwe, c, e_lat, e_nwe; logic [31:0] rd, wdin, cr, e_rd, a, wd; logic [AW-1:0] wa; logic ra, we;
    logic [31:0] offs [4];
    offs = '{32'h0, 32'h4, 32'h8, 32'h40};
    gpio_in = 16'h1234;
    model_access(1'b1, 32'hE000_0004, 32'h0000_00A5, cyc, e_rd, e_lat, e_nwe);
    access(1'b1, 32'hE000_0004, 32'h0000_00A5, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (gpio_out !== 32'hA5) begin n_fail++; $display("FAIL gpio_wr_led: got %h, expected a5", gpio_out); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL gpio_wr_latency: got %0d, expected 1", lat); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL gpio_wr_rdata: got %h, expected 0", rd); end
    model_access(1'b0, 32'hE000_0000, 32'h0, cyc, e_rd, e_lat, e_nwe);
    access(1'b0, 32'hE000_0000, 32'h0, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL gpio_rd_sw: got %h, expected 00001234", rd); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL gpio_rd_latency: got %0d, expected 1", lat); end
    for (int i = 0; i < 16; i++) begin
      gpio_in = 16'($urandom);
      we = 1'($urandom);
      wd = $urandom;
      a  = 32'hE000_0000 | offs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      model_access(we, a, wd, cyc, e_rd, e_lat, e_nwe);
      access(we, a, wd, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
      n_checks++; if (rd !== e_rd || lat != e_lat) begin n_fail++; $display("FAIL gpio_rand[%0d] a=%h we=%b: got rd=%h lat=%0d, expected rd=%h lat=%0d", i, a, we, rd, lat, e_rd, e_lat); end
      n_checks++; if (gpio_out !== gpio_m) begin n_fail++; $display("FAIL gpio_rand_led[%0d]: got %h, expected %h", i, gpio_out, gpio_m); end
    end
  endtask

  task automatic test_counter();
    int lat, nwe, c, e_lat, e_nwe; logic [31:0] rd, wdin, cr, e_rd, a, wd; logic [AW-1:0] wa; logic ra, we;
    model_access(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, cyc, e_rd, e_lat, e_nwe);
    access(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (cr !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cnt_load: got %h, expected fffffffe", cr); end
    n_checks++; if (cnt_val !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_incr: got %h, expected ffffffff", cnt_val); end
    model_access(1'b0, 32'hF000_0000, 32'h0, cyc, e_rd, e_lat, e_nwe);
    access(1'b0, 32'hF000_0000, 32'h0, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_read_sample: got %h, expected ffffffff", rd); end
    n_checks++; if (cr !== 32'h0) begin n_fail++; $display("FAIL cnt_wrap: got %h, expected 0", cr); end
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      we = ($urandom_range(0, 3) == 0);
      wd = $urandom;
      a  = {4'hF, 28'($urandom)};
      model_access(we, a, wd, cyc, e_rd, e_lat, e_nwe);
      access(we, a, wd, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
      n_checks++; if (rd !== e_rd || lat != e_lat) begin n_fail++; $display("FAIL cnt_rand[%0d] we=%b: got rd=%h lat=%0d, expected rd=%h lat=%0d", i, we, rd, lat, e_rd, e_lat); end
      n_checks++; if (cnt_val !== exp_cnt(cyc)) begin n_fail++; $display("FAIL cnt_rand_val[%0d]: got %h, expected %h", i, cnt_val, exp_cnt(cyc)); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, nwe, c, e_lat, e_nwe; logic [31:0] rd, wdin, cr, e_rd, wd; logic [AW-1:0] wa; logic ra;
    model_access(1'b1, 32'hE000_0004, 32'h5A5A_0001, cyc, e_rd, e_lat, e_nwe);
    access(1'b1, 32'hE000_0004, 32'h5A5A_0001, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    model_access(1'b0, 32'h0000_0010, 32'h0, cyc, e_rd, e_lat, e_nwe);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    n_checks++; if ({cpu_ready, ram_we} !== 2'b00) begin n_fail++; $display("FAIL rstmid_ready_we: got %b, expected 00", {cpu_ready, ram_we}); end
    n_checks++; if ({cpu_rdata, gpio_out} !== 64'h0) begin n_fail++; $display("FAIL rstmid_rdata_gpio: got %h/%h, expected 0/0", cpu_rdata, gpio_out); end
    n_checks++; if ({cnt_val, ram_din} !== 64'h0 || ram_addr !== '0) begin n_fail++; $display("FAIL rstmid_cnt_ram: got %h/%h/%h, expected 0/0/0", cnt_val, ram_din, ram_addr); end
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_hold: got %b, expected 0", cpu_ready); end
    rst = 1'b1;
    gpio_m = '0; last_rd = '0; cnt_base_val = '0; cnt_base_cyc = cyc;
    n_checks++; if (ram_mem[16] !== exp_mem[16]) begin n_fail++; $display("FAIL rstmid_no_write: got %h, expected %h", ram_mem[16], exp_mem[16]); end
    model_access(1'b0, 32'h0000_0040, 32'h0, cyc, e_rd, e_lat, e_nwe);
    access(1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (rd !== e_rd || lat != e_lat || nwe != 0) begin n_fail++; $display("FAIL rstmid_after_rd: got rd=%h lat=%0d nwe=%0d, expected rd=%h lat=%0d nwe=0", rd, lat, nwe, e_rd, e_lat); end
    wd = $urandom;
    model_access(1'b1, 32'h0000_0044, wd, cyc, e_rd, e_lat, e_nwe);
    access(1'b1, 32'h0000_0044, wd, 1'b0, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
    n_checks++; if (nwe != 1 || wa !== 10'd17 || wdin !== wd || lat != e_lat) begin n_fail++; $display("FAIL rstmid_after_wr: got nwe=%0d a=%h d=%h lat=%0d, expected nwe=1 a=011 d=%h lat=%0d", nwe, wa, wdin, lat, wd, e_lat); end
    n_checks++; if (cnt_val !== exp_cnt(cyc)) begin n_fail++; $display("FAIL rstmid_cnt: got %h, expected %h", cnt_val, exp_cnt(cyc)); end
  endtask

  task automatic test_back_to_back();
    int lat, nwe, c, e_lat, e_nwe, sel; logic [31:0] rd, wdin, cr, e_rd, a, wd; logic [AW-1:0] wa; logic ra, we;
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      we  = 1'($urandom);
      wd  = $urandom;
      gpio_in = 16'($urandom);
      if (sel == 2)      a = 32'hE000_0000 | 32'($urandom_range(0, 2) * 4);
      else if (sel == 3) a = {4'hF, 28'($urandom)};
      else               a = {4'($urandom_range(0, 13)), 28'($urandom)};
      model_access(we, a, wd, cyc, e_rd, e_lat, e_nwe);
      access(we, a, wd, 1'b1, 1'b0, lat, rd, nwe, wa, wdin, ra, c, cr);
      n_checks++; if (rd !== e_rd || lat != e_lat) begin n_fail++; $display("FAIL b2b[%0d] a=%h we=%b: got rd=%h lat=%0d, expected rd=%h lat=%0d", i, a, we, rd, lat, e_rd, e_lat); end
      n_checks++; if (nwe != e_nwe || ra !== 1'b0) begin n_fail++; $display("FAIL b2b_we_gap[%0d]: got nwe=%0d ready_after=%b, expected nwe=%0d ready_after=0", i, nwe, ra, e_nwe); end
      if (e_nwe == 1) begin
        n_checks++; if (wa !== a[11:2] || wdin !== wd) begin n_fail++; $display("FAIL b2b_ram_wr[%0d]: got %h/%h, expected %h/%h", i, wa, wdin, a[11:2], wd); end
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    int lat, nwe, c, e_lat, e_nwe; logic [31:0] rd, wdin, cr, e_rd, a, wd; logic [AW-1:0] wa; logic ra, we;
    for (int i = 0; i < 6; i++) begin
      we = 1'(i % 2 == 0);
      wd = $urandom;
      a  = {4'h1, 20'h0, 8'(i * 4)};
      model_access(we, a, wd, cyc, e_rd, e_lat, e_nwe);
      access(we, a, wd, 1'b0, 1'b1, lat, rd, nwe, wa, wdin, ra, c, cr);
      n_checks++; if (rd !== e_rd || lat != e_lat || nwe != e_nwe) begin n_fail++; $display("FAIL req_drop[%0d]: got rd=%h lat=%0d nwe=%0d, expected rd=%h lat=%0d nwe=%0d", i, rd, lat, nwe, e_rd, e_lat, e_nwe); end
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      exp_mem[i] = v;
    end
    test_reset();
    test_ram_write();
    test_ram_read();
    test_gpio();
    test_counter();
    test_reset_mid();
    test_back_to_back();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1);
  end

endmodule
